// File: rtl/seq_div.sv
// -----------------------------------------------------------------------------
// seq_div -- sequential unsigned divider, 2*WIDTH-bit dividend by WIDTH-bit
// divisor, one restoring step per clock.
//
// Ports
//   CLK          in   1        clock, rising-edge active
//   reset        in   1        synchronous active-high reset
//   start        in   1        request a division (accepted in IDLE or DONE)
//   in_dividend  in   2*WIDTH  unsigned dividend, latched on acceptance
//   in_divisor   in   WIDTH    unsigned divisor, latched on acceptance
//   quotient     out  WIDTH    unsigned quotient (meaningful when out_valid)
//   remainder    out  WIDTH    unsigned remainder (meaningful when out_valid)
//   busy         out  1        division in progress (CALC)
//   out_valid    out  1        result and flags hold a completed operation
//   div_by_zero  out  1        completed operation had divisor 0
//   overflow     out  1        true quotient does not fit in WIDTH bits
//
// Zero-divisor and overflow cases resolve on the accepting edge; all other
// operands take exactly WIDTH CALC steps.
// -----------------------------------------------------------------------------
module seq_div #(
    parameter int WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   in_dividend,
    input  logic [WIDTH-1:0]     in_divisor,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 busy,
    output logic                 out_valid,
    output logic                 div_by_zero,
    output logic                 overflow
);

    // Counter must reach WIDTH-1 without wrapping.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_divisor;
    // r_quot starts as the dividend low half; quotient bits shift in at the
    // LSB as dividend bits shift out at the MSB, so after WIDTH steps it
    // holds the quotient.
    logic [WIDTH-1:0]   r_quot;
    logic [WIDTH:0]     r_rem;
    logic               r_busy;
    logic               r_valid;
    logic               r_dbz;
    logic               r_ovf;

    state_t             w_state;
    logic [CW-1:0]      w_cnt;
    logic [WIDTH-1:0]   w_divisor;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH:0]     w_rem;
    logic               w_busy;
    logic               w_valid;
    logic               w_dbz;
    logic               w_ovf;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;

    // One restoring step: the bit shifted out of the partial remainder's top
    // position acts as a carry, so it forces the subtract when set.
    always_comb begin
        w_shift = {r_rem[WIDTH-1:0], r_quot[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_divisor};
        w_ge    = r_rem[WIDTH] | (w_shift >= {1'b0, r_divisor});
    end

    // Next-state and next-register logic; everything holds by default.
    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_divisor = r_divisor;
        w_quot    = r_quot;
        w_rem     = r_rem;
        w_busy    = r_busy;
        w_valid   = r_valid;
        w_dbz     = r_dbz;
        w_ovf     = r_ovf;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_divisor = in_divisor;
                    w_valid   = 1'b0;
                    w_dbz     = 1'b0;
                    w_ovf     = 1'b0;
                    w_cnt     = {CW{1'b0}};
                    if (in_divisor == {WIDTH{1'b0}}) begin
                        w_state = S_DONE;
                        w_dbz   = 1'b1;
                        w_valid = 1'b1;
                        w_busy  = 1'b0;
                        w_quot  = {WIDTH{1'b1}};
                        w_rem   = {1'b0, in_dividend[WIDTH-1:0]};
                    end else if (in_dividend[2*WIDTH-1:WIDTH] >= in_divisor) begin
                        w_state = S_DONE;
                        w_ovf   = 1'b1;
                        w_valid = 1'b1;
                        w_busy  = 1'b0;
                        w_quot  = {WIDTH{1'b1}};
                        w_rem   = {1'b0, in_dividend[WIDTH-1:0]};
                    end else begin
                        w_state = S_CALC;
                        w_busy  = 1'b1;
                        w_quot  = in_dividend[WIDTH-1:0];
                        w_rem   = {1'b0, in_dividend[2*WIDTH-1:WIDTH]};
                    end
                end else begin
                    w_state = r_state;
                end
            end
            S_CALC: begin
                // start is deliberately not looked at here.
                w_quot = {r_quot[WIDTH-2:0], w_ge};
                w_rem  = w_ge ? w_diff : w_shift;
                w_cnt  = r_cnt + {{(CW-1){1'b0}}, 1'b1};
                if (r_cnt == CW'(WIDTH - 1)) begin
                    w_state = S_DONE;
                    w_busy  = 1'b0;
                    w_valid = 1'b1;
                end else begin
                    w_state = S_CALC;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
                w_valid = 1'b0;
                w_dbz   = 1'b0;
                w_ovf   = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= {CW{1'b0}};
            r_divisor <= {WIDTH{1'b0}};
            r_quot    <= {WIDTH{1'b0}};
            r_rem     <= {(WIDTH+1){1'b0}};
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_dbz     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_divisor <= w_divisor;
            r_quot    <= w_quot;
            r_rem     <= w_rem;
            r_busy    <= w_busy;
            r_valid   <= w_valid;
            r_dbz     <= w_dbz;
            r_ovf     <= w_ovf;
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem[WIDTH-1:0];
    assign busy        = r_busy;
    assign out_valid   = r_valid;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_seq_div.sv
// -----------------------------------------------------------------------------
// tb_seq_div -- directed self-checking bench for seq_div (WIDTH = 32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seq_div;

    localparam int W = 32;

    logic             CLK;
    logic             reset;
    logic             start;
    logic [2*W-1:0]   in_dividend;
    logic [W-1:0]     in_divisor;
    logic [W-1:0]     quotient;
    logic [W-1:0]     remainder;
    logic             busy;
    logic             out_valid;
    logic             div_by_zero;
    logic             overflow;

    int n_cmp  = 0;
    int n_fail = 0;
    int lat;

    seq_div #(.WIDTH(W)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .start       (start),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .out_valid   (out_valid),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                             input logic b, input logic v, input logic z, input logic o);
        check({tag, ".quotient"},  {32'd0, quotient},  {32'd0, q});
        check({tag, ".remainder"}, {32'd0, remainder}, {32'd0, r});
        check({tag, ".busy"},      {63'd0, busy},        {63'd0, b});
        check({tag, ".out_valid"}, {63'd0, out_valid},   {63'd0, v});
        check({tag, ".div_by_zero"}, {63'd0, div_by_zero}, {63'd0, z});
        check({tag, ".overflow"},  {63'd0, overflow},    {63'd0, o});
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic start_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        in_dividend = dvd;
        in_divisor  = dvs;
        start       = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        start       = 1'b0;
    endtask

    // Counts edges after acceptance until out_valid; optionally pulses start
    // with unrelated operands before edge number pulse_at+1.
    task automatic wait_valid(input int pulse_at, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            if (n == pulse_at) begin
                start       = 1'b1;
                in_dividend = 64'd555;
                in_divisor  = 32'd0;
            end else begin
                start       = 1'b0;
            end
            @(posedge CLK);
            @(negedge CLK);
            start = 1'b0;
            n++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        in_dividend = 64'd0;
        in_divisor  = 32'd0;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check_all("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge CLK);

        // Exact quotient.
        start_op(64'd2700, 32'd90);
        check("exact.busy", {63'd0, busy}, 64'd1);
        check("exact.valid0", {63'd0, out_valid}, 64'd0);
        wait_valid(-1, lat);
        check("exact.latency", 64'(lat), 64'd32);
        check_all("exact", 32'd30, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Result holds in DONE.
        repeat (5) @(negedge CLK);
        check_all("hold", 32'd30, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Largest non-overflowing operands.
        start_op(64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
        wait_valid(-1, lat);
        check("max.latency", 64'(lat), 64'd32);
        check_all("max", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Remainder, with a start pulse that must be ignored mid-CALC.
        start_op(64'd2701, 32'd90);
        wait_valid(5, lat);
        check("midstart.latency", 64'(lat), 64'd32);
        check_all("midstart", 32'd30, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Division by zero from DONE.
        start_op(64'd2700, 32'd0);
        check_all("dbz", 32'hFFFF_FFFF, 32'd2700, 1'b0, 1'b1, 1'b1, 1'b0);

        // Overflow.
        start_op(64'h1_0000_0000, 32'd1);
        check_all("ovf", 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Just below overflow.
        start_op(64'h1_0000_0001, 32'd2);
        check("noovf.busy", {63'd0, busy}, 64'd1);
        wait_valid(-1, lat);
        check("noovf.latency", 64'(lat), 64'd32);
        check_all("noovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset 10 cycles into CALC, with a zero-divisor start on the same edge.
        start_op(64'd1000, 32'd3);
        repeat (10) begin
            @(posedge CLK);
            @(negedge CLK);
        end
        reset       = 1'b1;
        start       = 1'b1;
        in_dividend = 64'd77;
        in_divisor  = 32'd0;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        start = 1'b0;
        check_all("rstcalc", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        check_all("rstidle", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        start_op(64'd90, 32'd9);
        wait_valid(-1, lat);
        check("afterrst.latency", 64'(lat), 64'd32);
        check_all("afterrst", 32'd10, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Back-to-back: start in the first DONE cycle.
        start_op(64'd100, 32'd7);
        check("b2b.valid0", {63'd0, out_valid}, 64'd0);
        check("b2b.busy", {63'd0, busy}, 64'd1);
        wait_valid(-1, lat);
        check("b2b.latency", 64'(lat), 64'd32);
        check_all("b2b", 32'd14, 32'd2, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter WIDTH, default 32: divisor, quotient and remainder width; dividend is 2*WIDTH bits.
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 start  input  1  request a division; sampled on the rising edge.
REQ-005 in_dividend  input  2*WIDTH  unsigned dividend; sampled on the edge that accepts start.
REQ-006 in_divisor  input  WIDTH  unsigned divisor; sampled on the edge that accepts start.
REQ-007 quotient  output  WIDTH  unsigned quotient.
REQ-008 remainder  output  WIDTH  unsigned remainder.
REQ-009 busy  output  1  high while a division is in progress (state CALC).
REQ-010 out_valid  output  1  high while quotient, remainder and the flags hold a completed result.
REQ-011 div_by_zero  output  1  the completed operation had divisor 0.
REQ-012 overflow  output  1  the true quotient does not fit in WIDTH bits.

Function
REQ-013 The FSM SHALL have three states:
  - IDLE: no result held.
  - CALC: division in progress.
  - DONE: result held.
REQ-014 start SHALL be accepted only in IDLE or DONE; start in CALC SHALL be ignored, with no effect on inputs, counter or result.
REQ-015 On acceptance the block SHALL latch both operands, clear out_valid, div_by_zero and overflow, and select its next state by the operand class (REQ-016 to REQ-018).
REQ-016 Divisor 0 (checked first):
  - next state DONE on the same edge;
  - div_by_zero=1, overflow=0;
  - quotient = all ones, remainder = in_dividend[WIDTH-1:0];
  - out_valid=1 one cycle after acceptance.
REQ-017 Nonzero divisor with in_dividend[2*WIDTH-1:WIDTH] >= in_divisor:
  - overflow=1, div_by_zero=0;
  - quotient = all ones, remainder = in_dividend[WIDTH-1:0];
  - next state DONE, out_valid=1 one cycle after acceptance.
REQ-018 Otherwise the next state SHALL be CALC with busy=1.
  - The partial remainder (WIDTH+1 bits) SHALL be loaded with the dividend high half.
  - The iteration counter SHALL be loaded with 0.
REQ-019 Each CALC edge SHALL perform one restoring step:
  - shift {partial remainder, dividend low bits} left by one;
  - compare against the divisor, subtract if >=, and shift the quotient bit (1 on subtract, else 0) into the quotient LSB;
  - increment the counter.
REQ-020 After exactly WIDTH CALC steps the state SHALL become DONE on the edge of the final step.
  - busy=0, out_valid=1.
  - quotient and remainder SHALL be final: in_dividend = quotient*in_divisor + remainder, and remainder < in_divisor.
  - Latency from the accepting edge to out_valid visible is exactly WIDTH cycles (32 by default).
REQ-021 In DONE all outputs SHALL hold until the next accepted start or reset; out_valid SHALL stay high indefinitely.
REQ-022 A start accepted in DONE SHALL drop out_valid on that same edge; the old result need not be preserved.
REQ-023 quotient and remainder SHALL NOT be interpreted while out_valid=0; their values in CALC are unspecified.
REQ-024 The counter SHALL be wide enough to count WIDTH steps without wrap (6 bits for WIDTH=32).
REQ-025 All arithmetic SHALL be unsigned; no signed interpretation of any operand.

Reset
REQ-026 reset=1 at a rising edge SHALL force:
  - state IDLE, counter 0;
  - quotient=0, remainder=0;
  - busy=0, out_valid=0, div_by_zero=0, overflow=0.
REQ-027 reset SHALL take priority over start on the same edge.
REQ-028 Reset during CALC or DONE SHALL abort or discard the operation with no residual effect on the next division.

Verification
REQ-029 Exact quotient, WIDTH=32: dividend 2700, divisor 90, start 1 cycle.
  - out_valid rises exactly 32 cycles after acceptance.
  - quotient=30, remainder=0, flags 0.
REQ-030 Largest non-overflowing operands: dividend 64'hFFFFFFFE00000001, divisor 32'hFFFFFFFF.
  - quotient=32'hFFFFFFFF, remainder=0, overflow=0.
REQ-031 Remainder and busy start, then division by zero:
  - dividend 2701, divisor 90 -> quotient 30, remainder 1.
  - start pulsed again mid-CALC -> ignored; result unchanged and on time.
  - dividend 2700, divisor 0 -> one cycle later div_by_zero=1, quotient=32'hFFFFFFFF, remainder=2700.
REQ-032 Overflow: dividend 64'h1_0000_0000, divisor 1.
  - overflow=1 one cycle after acceptance, quotient=32'hFFFFFFFF, remainder=0.
  - dividend 64'h1_0000_0001, divisor 2 -> overflow=0, quotient=32'h80000000, remainder=1.
REQ-033 Reset mid-operation:
  - reset asserted 10 cycles into CALC -> next cycle all outputs 0, state IDLE.
  - new start with 90/9 -> quotient 10, remainder 0 after 32 cycles.
REQ-034 Back-to-back: start asserted in the first DONE cycle of a result.
  - out_valid drops on that edge; the next result is valid 32 cycles later.
